// File: rtl/cp0_unit.sv
// cp0_unit -- Coprocessor-0 responder for the pipelined MIPS core.
// Executes mfc0/mtc0/eret issued from the M stage, holds SR, Cause, EPC and
// PRId, arbitrates external interrupts against synchronous exceptions and
// raises one flush/redirect request. The M-stage instruction is the victim
// of any exception taken in a cycle.
//
// Optional feature macro: CP0_TIMER_EN adds Count (reg 9) and Compare
// (reg 11) with a sticky match bit ORed into interrupt line 5.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-high reset
//   we          mtc0 write strobe
//   addr        CP0 register number (read and write)
//   din         mtc0 write data
//   dout        mfc0 read data (combinational)
//   vpc         PC of the M-stage instruction
//   bd_in       M-stage instruction is in a branch delay slot
//   exc_code_in pending exception code (0 = none)
//   hw_int      level-sensitive external interrupt lines
//   eret        eret executing in M
//   req         take exception/interrupt this cycle (combinational)
//   epc_out     registered EPC, the eret target
module cp0_unit #(
    parameter logic [31:0] PRID = 32'h2024_0501
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    input  logic [31:0] vpc,
    input  logic        bd_in,
    input  logic [4:0]  exc_code_in,
    input  logic [5:0]  hw_int,
    input  logic        eret,
    output logic        req,
    output logic [31:0] epc_out
);

    // SR fields
    logic [5:0]  im_q;
    logic        exl_q;
    logic        ie_q;
    // Cause fields
    logic        bd_q;
    logic [5:0]  ip_q;
    logic [4:0]  exc_code_q;
    // EPC, bits [1:0] always zero
    logic [31:0] epc_q;

    logic [5:0]  irq_lines;
    logic        int_req;
    logic        exc_req;
    logic [31:0] epc_d;
    logic        wr_ok;

`ifdef CP0_TIMER_EN
    logic [31:0] count_q;
    logic [31:0] compare_q;
    logic        timer_pend_q;

    assign irq_lines = {hw_int[5] | timer_pend_q, hw_int[4:0]};
`else
    assign irq_lines = hw_int;
`endif

    assign int_req = !exl_q && ie_q && (|(im_q & irq_lines));
    assign exc_req = !exl_q && (exc_code_in != 5'd0);
    assign req     = int_req | exc_req;
    assign epc_out = epc_q;

    // mtc0 and eret are suppressed in a cycle that takes an exception
    assign wr_ok = !req;

    // Victim PC: a delay-slot instruction restarts at its branch
    always_comb begin
        epc_d = bd_in ? (vpc - 32'd4) : vpc;
        epc_d = {epc_d[31:2], 2'b00};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ip_q       <= '0;
            exc_code_q <= '0;
            epc_q      <= '0;
        end else begin
            ip_q <= irq_lines;
            if (req) begin
                exl_q      <= 1'b1;
                exc_code_q <= int_req ? 5'd0 : exc_code_in;
                bd_q       <= bd_in;
                epc_q      <= epc_d;
            end else begin
                if (we && addr == 5'd12) begin
                    im_q  <= din[15:10];
                    ie_q  <= din[0];
                    exl_q <= din[1];
                end
                if (we && addr == 5'd14)
                    epc_q <= {din[31:2], 2'b00};
                // eret overrides the EXL field of a same-cycle SR write
                if (eret)
                    exl_q <= 1'b0;
            end
        end
    end

`ifdef CP0_TIMER_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q      <= '0;
            compare_q    <= '0;
            timer_pend_q <= 1'b0;
        end else begin
            if (wr_ok && we && addr == 5'd9)
                count_q <= din;
            else
                count_q <= count_q + 32'd1;
            // A Compare write clears the pend bit even if it matches now
            if (wr_ok && we && addr == 5'd11) begin
                compare_q    <= din;
                timer_pend_q <= 1'b0;
            end else if (count_q == compare_q) begin
                timer_pend_q <= 1'b1;
            end
        end
    end
`endif

    always_comb begin
        dout = '0;
        case (addr)
            5'd12:   dout = {16'b0, im_q, 8'b0, exl_q, ie_q};
            5'd13:   dout = {bd_q, 15'b0, ip_q, 3'b0, exc_code_q, 2'b0};
            5'd14:   dout = epc_q;
            5'd15:   dout = PRID;
`ifdef CP0_TIMER_EN
            5'd9:    dout = count_q;
            5'd11:   dout = compare_q;
`endif
            default: dout = '0;
        endcase
    end

endmodule
